seq_det_ctx_sched: RTL

Round-robin scheduler that time-shares one overlapping "11001" Mealy detector datapath among NCH serial bit streams. It holds a per-channel detector context and per-channel hit counters. Each cycle it grants at most one requesting channel, restores that channel's context into the shared next-state/output logic, and writes the updated context back. It sits between the serial front-end channels and the status/interrupt logic.

---
 rtl/seq_det_ctx_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_det_ctx_sched.sv
// ---------------------------------------------------------------------------
// seq_det_ctx_sched
//
// Time-shares one overlapping "11001" Mealy detector among NCH serial bit
// streams. Each cycle a round-robin arbiter grants at most one eligible
// channel. That channel's saved detector state goes through the shared
// transition logic, and the result is written back to the same channel.
// Hit counters are kept per channel and saturate at their maximum value.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bit_valid  : [NCH] channel i offers a serial bit
//   bit_data   : [NCH] serial bit of channel i
//   bit_ready  : [NCH] one-hot/zero grant (combinational, no bit_data path)
//   ch_clr     : [NCH] synchronous clear of channel i state and counter
//   det_valid  : one-cycle pulse, pattern completed
//   det_ch     : [CW] channel that completed the pattern
//   rd_ch      : [CW] counter read select
//   rd_count   : [CNTW] hit counter of channel rd_ch (combinational)
// ---------------------------------------------------------------------------
module seq_det_ctx_sched #(
   parameter int NCH  = 4,
   parameter int CW   = 2,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NCH-1:0]  bit_valid,
   input  logic [NCH-1:0]  bit_data,
   output logic [NCH-1:0]  bit_ready,
   input  logic [NCH-1:0]  ch_clr,
   output logic            det_valid,
   output logic [CW-1:0]   det_ch,
   input  logic [CW-1:0]   rd_ch,
   output logic [CNTW-1:0] rd_count
);

   typedef enum logic [2:0] {
      S0 = 3'd0,  // idle
      S1 = 3'd1,  // "1"
      S2 = 3'd2,  // "11"
      S3 = 3'd3,  // "110"
      S4 = 3'd4   // "1100"
   } state_t;

   // Shared detector transition. A hit is S4 followed by a 1, which is
   // decoded separately.
   function automatic state_t next_state(input state_t s, input logic b);
      case (s)
         S0:      return b ? S1 : S0;
         S1:      return b ? S2 : S0;
         S2:      return b ? S2 : S3;
         S3:      return b ? S1 : S4;
         S4:      return b ? S1 : S0;
         default: return S0;
      endcase
   endfunction

   state_t          ctx_q [NCH];
   logic [CNTW-1:0] cnt_q [NCH];
   logic [CW-1:0]   ptr_q;
   logic            det_valid_q;
   logic [CW-1:0]   det_ch_q;

   logic [NCH-1:0]  eligible;
   logic [NCH-1:0]  grant;
   logic            grant_any;
   logic [CW-1:0]   grant_idx;
   logic [CW-1:0]   cand;
   state_t          cur_state;
   logic            cur_bit;
   state_t          ctx_d;
   logic [CNTW-1:0] cnt_d;
   logic [CW-1:0]   ptr_d;
   logic            hit;

   // A channel being cleared is masked, so its bit stays on the input.
   assign eligible = bit_valid & ~ch_clr;

   // Search ptr, ptr+1, ... modulo NCH, and keep the first eligible channel.
   always_comb begin
      // NOTE: each variable gets a default before any conditional assignment.
      // Without the default, a path that skips the assignment infers a latch.
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int off = 0; off < NCH; off++) begin
         cand = CW'((int'(ptr_q) + off) % NCH);
         if (!grant_any && eligible[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign grant     = grant_any ? (NCH'(1) << grant_idx) : '0;
   assign bit_ready = rst_n ? grant : '0;

   assign cur_state = ctx_q[grant_idx];
   assign cur_bit   = bit_data[grant_idx];
   assign ctx_d     = next_state(cur_state, cur_bit);
   assign hit       = grant_any && (cur_state == S4) && cur_bit;
   assign cnt_d     = (hit && (cnt_q[grant_idx] != '1)) ? cnt_q[grant_idx] + CNTW'(1)
                                                       : cnt_q[grant_idx];
   assign ptr_d     = !grant_any                  ? ptr_q :
                      (grant_idx == CW'(NCH - 1)) ? '0    : grant_idx + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the per-channel context is a small register array, not a RAM.
         // It must be reset so that every stream starts from idle.
         for (int i = 0; i < NCH; i++) begin
            ctx_q[i] <= S0;
            cnt_q[i] <= '0;
         end
         ptr_q       <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples values from before the edge.
         ptr_q       <= ptr_d;
         det_valid_q <= hit;
         if (hit) det_ch_q <= grant_idx;
         if (grant_any) begin
            ctx_q[grant_idx] <= ctx_d;
            cnt_q[grant_idx] <= cnt_d;
         end
         // The clear comes last and wins. A pulse already decoded this cycle
         // still goes out through det_valid_q.
         for (int i = 0; i < NCH; i++) begin
            if (ch_clr[i]) begin
               ctx_q[i] <= S0;
               cnt_q[i] <= '0;
            end
         end
      end
   end

   // Read view padded to 2**CW entries, so that any rd_ch value is a legal index.
   logic [CNTW-1:0] cnt_rd [2**CW];
   for (genvar gi = 0; gi < 2**CW; gi++) begin : g_rd
      if (gi < NCH) begin : g_real
         assign cnt_rd[gi] = cnt_q[gi];
      end else begin : g_pad
         assign cnt_rd[gi] = '0;
      end
   end

   assign rd_count  = rst_n ? cnt_rd[rd_ch] : '0;
   assign det_valid = det_valid_q;
   assign det_ch    = det_ch_q;

endmodule
